// File: rtl/video_out_gen_if.sv
// Read side of the show-ahead video FIFO, as seen by the video output generator.
// master: the consumer that pops symbols. slave: the FIFO that presents them.
interface video_out_gen_if #(
  parameter int SYM_W   = 4,
  parameter int USEDW_W = 9
) ();
  logic [SYM_W-1:0]   fifor_data;
  logic               fifor_empty;
  logic [USEDW_W-1:0] fifor_used_words;
  logic               fifor_acknowledge;

  modport master (
    input  fifor_data,
    input  fifor_empty,
    input  fifor_used_words,
    output fifor_acknowledge
  );

  modport slave (
    output fifor_data,
    output fifor_empty,
    output fifor_used_words,
    input  fifor_acknowledge
  );
endinterface

// File: rtl/video_out_gen.sv
// Raster generator: maps FIFO symbols to luma levels with its own H/V timing and composite sync.
// Define TRAINING_LINE_EN to make the first active line of each frame a calibration staircase.
module video_out_gen #(
  parameter int SYM_W          = 4,
  parameter int LUMA_W         = 8,
  parameter int USEDW_W        = 9,
  parameter int BLACK_LEVEL    = 64,
  parameter int LUMA_STEP      = 12,
  parameter int SYNC_LEVEL     = 0,
  parameter int H_TOTAL        = 400,
  parameter int H_SYNC         = 30,
  parameter int H_ACT_START    = 60,
  parameter int H_ACT_LEN      = 320,
  parameter int V_TOTAL        = 262,
  parameter int V_SYNC_LINES   = 3,
  parameter int V_ACT_START    = 20,
  parameter int V_ACT_LINES    = 240,
  parameter int PIXELS_PER_SYM = 2,
  parameter int PREFILL        = 160
) (
  input  logic                 clk,
  input  logic                 rst,
  video_out_gen_if.master      fifo,
  output logic [LUMA_W-1:0]    video_out,
  output logic                 sync,
  output logic                 active,
  output logic                 frame_start,
  output logic                 streaming,
  output logic                 underrun,
  input  logic                 underrun_clr,
  output logic [15:0]          underrun_cnt
);

  localparam int H_W = $clog2(H_TOTAL + 1);
  localparam int V_W = $clog2(V_TOTAL + 1);
  localparam int P_W = $clog2(PIXELS_PER_SYM + 1);

  localparam logic [H_W-1:0]     H_LAST      = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0]     H_SYNC_END  = H_W'(H_SYNC);
  localparam logic [H_W-1:0]     H_BROAD_END = H_W'(H_TOTAL - H_SYNC);
  localparam logic [H_W-1:0]     H_ACT_S     = H_W'(H_ACT_START);
  localparam logic [H_W-1:0]     H_ACT_E     = H_W'(H_ACT_START + H_ACT_LEN);
  localparam logic [V_W-1:0]     V_LAST      = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]     V_SYNC_END  = V_W'(V_SYNC_LINES);
  localparam logic [V_W-1:0]     V_ACT_S     = V_W'(V_ACT_START);
  localparam logic [V_W-1:0]     V_ACT_E     = V_W'(V_ACT_START + V_ACT_LINES);
  localparam logic [P_W-1:0]     P_LAST      = P_W'(PIXELS_PER_SYM - 1);
  localparam logic [LUMA_W-1:0]  LUMA_BLACK  = LUMA_W'(BLACK_LEVEL);
  localparam logic [LUMA_W-1:0]  LUMA_SYNC   = LUMA_W'(SYNC_LEVEL);
  localparam logic [LUMA_W-1:0]  LUMA_INC    = LUMA_W'(LUMA_STEP);
  localparam logic [USEDW_W-1:0] USED_MIN    = USEDW_W'(PREFILL);

  // Wraps modulo 2^LUMA_W on purpose: large symbols fold back rather than clip.
  function automatic logic [LUMA_W-1:0] luma_of(input logic [SYM_W-1:0] s);
    return LUMA_BLACK + LUMA_INC * LUMA_W'(s);
  endfunction

  logic [H_W-1:0]    h_q, h_d;
  logic [V_W-1:0]    v_q, v_d;
  logic [P_W-1:0]    slot_pix_q, slot_pix_d;
  logic [LUMA_W-1:0] slot_luma_q, slot_luma_d;
  logic [LUMA_W-1:0] video_q, video_d;
  logic              sync_q, sync_d;
  logic              active_q, active_d;
  logic              frame_start_q, frame_start_d;
  logic              streaming_q, streaming_d;
  logic              ack_q, ack_d;
  logic              underrun_q, underrun_d;
  logic [15:0]       cnt_q, cnt_d;

  logic              in_win;
  logic              slot_first;
  logic              train_line;
  logic [SYM_W-1:0]  train_sym;
  logic              take;
  logic              starve;

`ifdef TRAINING_LINE_EN
  logic [SYM_W-1:0]  slot_idx_q, slot_idx_d;

  // Slot index wraps modulo 2^SYM_W, giving a repeating staircase.
  always_comb begin
    slot_idx_d = '0;
    if (in_win) begin
      slot_idx_d = (slot_pix_q == P_LAST) ? slot_idx_q + 1'b1 : slot_idx_q;
    end
    train_line = (v_q == V_ACT_S);
    train_sym  = slot_idx_q;
  end

  always_ff @(posedge clk) begin
    if (rst) slot_idx_q <= '0;
    else     slot_idx_q <= slot_idx_d;
  end
`else
  always_comb begin
    train_line = 1'b0;
    train_sym  = '0;
  end
`endif

  always_comb begin
    h_d = (h_q == H_LAST) ? '0 : h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end

    frame_start_d = (h_q == '0) && (v_q == '0);
    streaming_d   = frame_start_d ? (fifo.fifor_used_words >= USED_MIN) : streaming_q;

    // Broad pulses on the first lines invert the usual narrow hsync.
    sync_d = (v_q < V_SYNC_END) ? (h_q >= H_BROAD_END) : (h_q >= H_SYNC_END);

    in_win   = (h_q >= H_ACT_S) && (h_q < H_ACT_E) && (v_q >= V_ACT_S) && (v_q < V_ACT_E);
    active_d = in_win;

    slot_first = in_win && (slot_pix_q == '0);
    slot_pix_d = (in_win && (slot_pix_q != P_LAST)) ? slot_pix_q + 1'b1 : '0;

    take   = slot_first && streaming_q && !train_line && !fifo.fifor_empty;
    starve = slot_first && streaming_q && !train_line &&  fifo.fifor_empty;
    ack_d  = take;

    slot_luma_d = slot_luma_q;
    if (slot_first) begin
      if (train_line)  slot_luma_d = luma_of(train_sym);
      else if (take)   slot_luma_d = luma_of(fifo.fifor_data);
      else             slot_luma_d = LUMA_BLACK;
    end

    if (!sync_d)     video_d = LUMA_SYNC;
    else if (in_win) video_d = slot_luma_d;
    else             video_d = LUMA_BLACK;

    // A starved slot in the same cycle as a clear restarts the count at one.
    underrun_d = underrun_q;
    cnt_d      = cnt_q;
    if (starve) begin
      underrun_d = 1'b1;
      if (underrun_clr)         cnt_d = 16'd1;
      else if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end else if (underrun_clr) begin
      underrun_d = 1'b0;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q           <= '0;
      v_q           <= '0;
      slot_pix_q    <= '0;
      slot_luma_q   <= LUMA_BLACK;
      video_q       <= LUMA_BLACK;
      sync_q        <= 1'b1;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
      streaming_q   <= 1'b0;
      ack_q         <= 1'b0;
      underrun_q    <= 1'b0;
      cnt_q         <= '0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      slot_pix_q    <= slot_pix_d;
      slot_luma_q   <= slot_luma_d;
      video_q       <= video_d;
      sync_q        <= sync_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
      streaming_q   <= streaming_d;
      ack_q         <= ack_d;
      underrun_q    <= underrun_d;
      cnt_q         <= cnt_d;
    end
  end

  assign video_out              = video_q;
  assign sync                   = sync_q;
  assign active                 = active_q;
  assign frame_start            = frame_start_q;
  assign streaming              = streaming_q;
  assign fifo.fifor_acknowledge = ack_q;
  assign underrun               = underrun_q;
  assign underrun_cnt           = cnt_q;

endmodule

// File: doc/video_out_gen.md
Name: video_out_gen

Overview:
- Parametrised successor to the NTSC video output stage.
- Reads N-bit symbols from the show-ahead video output FIFO (read side, pixel clock domain) and maps each symbol to one of 2^SYM_W luminance levels.
- Holds each level for PIXELS_PER_SYM pixels and generates its own horizontal and vertical timing and composite sync.
- Adds per-frame prefill gating, underrun detection and counting, and runtime-free generalisation of symbol width and raster geometry.

Parameters:
SYM_W, 4, bits per FIFO symbol
LUMA_W, 8, DAC word width
USEDW_W, 9, width of FIFO used-words port
BLACK_LEVEL, 64, luma for symbol 0 and for non-data pixels
LUMA_STEP, 12, luma increment per symbol value (symbol 15 gives 244)
SYNC_LEVEL, 0, luma during sync pulses
H_TOTAL, 400, pixels per line
H_SYNC, 30, hsync width in pixels
H_ACT_START, 60, first active pixel
H_ACT_LEN, 320, active pixels per line (multiple of PIXELS_PER_SYM)
V_TOTAL, 262, lines per frame (progressive)
V_SYNC_LINES, 3, broad-pulse lines at frame start
V_ACT_START, 20, first active line
V_ACT_LINES, 240, active lines
PIXELS_PER_SYM, 2, pixels per symbol
PREFILL, 160, minimum used words required at frame start to stream that frame

Ports:
clk  in  1  pixel clock (clk_ntsc)
rst  in  1  synchronous, active-high reset
fifor_data  in  SYM_W  show-ahead FIFO head; valid when fifor_empty=0
fifor_empty  in  1  FIFO empty
fifor_used_words  in  USEDW_W  FIFO read-side fill level
fifor_acknowledge  out  1  one-cycle pop of the FIFO head
video_out  out  LUMA_W  registered DAC value
sync  out  1  composite sync, active low
active  out  1  high while the current output pixel is in the active window
frame_start  out  1  one-cycle pulse coincident with output of pixel h=0, v=0
streaming  out  1  current frame is consuming FIFO data
underrun  out  1  sticky underrun flag
underrun_clr  in  1  clears underrun and underrun_cnt
underrun_cnt  out  16  saturating underrun-symbol count

Behaviour:
Reset values:
- Counters h=v=0; video_out=BLACK_LEVEL; sync=1.
- fifor_acknowledge, active, frame_start, streaming, underrun = 0; underrun_cnt=0.
- Reset asserted mid-frame takes effect at the next edge and never issues an ack.

Timing:
- h wraps at H_TOTAL-1 to 0 and then increments v; v wraps at V_TOTAL-1 to 0.
- All outputs are registered: each output lags its (h,v) by exactly one cycle.

Sync and blanking:
- Lines v < V_SYNC_LINES: sync=0 for h < H_TOTAL-H_SYNC, else 1.
- Other lines: sync=0 for h < H_SYNC.
- video_out=SYNC_LEVEL whenever sync=0.
- Active window: H_ACT_START <= h < H_ACT_START+H_ACT_LEN and V_ACT_START <= v < V_ACT_START+V_ACT_LINES.
- Non-sync pixels outside the window output BLACK_LEVEL.

Frame arming:
- At h=0, v=0, streaming latches (fifor_used_words >= PREFILL) and holds for the whole frame.
- Unarmed frame: the active window outputs BLACK_LEVEL, issues no acks, and counts no underruns.

Symbol slots:
- Each active line has H_ACT_LEN/PIXELS_PER_SYM slots.
- At the first pixel of each slot while streaming:
  - fifor_empty=0: latch fifor_data, assert fifor_acknowledge that cycle, output BLACK_LEVEL + sym*LUMA_STEP (LUMA_W-bit arithmetic, computed unsigned) for the whole slot.
  - fifor_empty=1: no ack; slot outputs BLACK_LEVEL; underrun set; underrun_cnt increments, saturating at 65535.
- Exactly one ack per non-underrun slot, never outside the active window.

Counter control:
- underrun_clr and an underrun event in the same cycle: the set/increment wins (flag=1, cnt=1).

Optional Feature:
TRAINING_LINE_EN:
- Defined: the first active line of every frame is a calibration staircase.
  - Slot k outputs BLACK_LEVEL + (k mod 2^SYM_W)*LUMA_STEP.
  - No acks and no underrun accounting on that line.
  - Streaming frames consume data starting at the second active line.
- Undefined: all active lines carry FIFO data as above.

Test Plan:
- Reset, FIFO empty, run 2 frames -> frame_start every 104800 cycles; sync low 30 pixels per line and broad pulses on lines 0-2; video_out only 0 or 64; no acks.
- used_words=200 at frame start, FIFO holds 160 symbols 0..15 repeating -> streaming=1; 160 acks on line 20, one per 2 pixels; luma sequence 64,64,76,76,…,244,244; no underrun.
- used_words=100 at frame start -> streaming=0 for the whole frame; zero acks even if FIFO fills mid-frame.
- Armed frame, FIFO drains after 50 symbols -> slots 51..160 of line 20 output 64; underrun=1; underrun_cnt=110; no ack while empty.
- underrun_clr pulsed on the same cycle as a new underrun -> underrun=1, underrun_cnt=1.
- Assert rst mid-active-line -> next cycle video_out=64, sync=1, ack=0; h,v restart at 0 and frame_start occurs 1 cycle after rst release.
